// File: rtl/video_pkg.sv
// Shared definitions for the tile fetch pipeline: timing defaults,
// the pixel-phase slots of the fetch sequence and the fetch-state enum.
package video_pkg;

  localparam int H_TOTAL_DEF = 384;
  localparam int V_TOTAL_DEF = 264;

  // Phase (hcnt[2:0]) at which each fetch step fires
  localparam logic [2:0] PH_ADDR = 3'd1;
  localparam logic [2:0] PH_CODE = 3'd3;
  localparam logic [2:0] PH_ROW  = 3'd5;
  localparam logic [2:0] PH_LOAD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CODE = 3'd2,
    ST_ROW  = 3'd3,
    ST_LOAD = 3'd4
  } fetch_st_e;

  // The fetch state is a pure function of the pixel phase, so a jump in
  // hcnt is followed immediately without any stored sequencing state.
  function automatic fetch_st_e decode_phase(input logic [2:0] ph);
    case (ph)
      PH_ADDR: return ST_ADDR;
      PH_CODE: return ST_CODE;
      PH_ROW:  return ST_ROW;
      PH_LOAD: return ST_LOAD;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tile_shifter.sv
// 8-bit glyph row shifter (MSB first) with the palette latch that travels
// alongside the row it belongs to.
module tile_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] din,
  input  logic [2:0] cin,
  output logic       pix,
  output logic [2:0] color
);

  logic [7:0] r_sh;
  logic [2:0] r_col;

  // Load a new row on the load slot, otherwise shift left with zero fill
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh  <= 8'h00;
      r_col <= 3'd0;
    end else if (ce) begin
      if (load) begin
        r_sh  <= din;
        r_col <= cin;
      end else begin
        r_sh  <= {r_sh[6:0], 1'b0};
      end
    end
  end

  assign pix   = r_sh[7];
  assign color = r_col;

endmodule

// File: rtl/video_tile_fetch.sv
// Character-tile background fetcher: every 8 pixels it reads the tile map,
// then the character ROM, and hands the glyph row to the pixel shifter so
// it is displayed during the following 8-pixel cell.
module video_tile_fetch
  import video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        page,
  output logic [10:0] vram_addr,
  input  logic [7:0]  vram_q,
  output logic [10:0] chr_addr,
  input  logic [7:0]  chr_q,
  output logic        pix_out,
  output logic [2:0]  pix_color
);

  // Last 8 pixels of a line prefetch column 0 of the next line
  localparam logic [8:0] H_LAST_CELL = 9'(H_TOTAL - 8);
  localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);

  fetch_st_e  w_state;
  logic       w_late;
  logic [4:0] w_fc;
  logic [7:0] w_fl;
  logic       w_primed;
  logic       w_load;
  logic       w_pix;
  logic [2:0] w_color;

  logic [10:0] r_vram_addr;
  logic [10:0] r_chr_addr;
  logic [2:0]  r_code_pal;   // palette bits of the pending code; glyph bits already left on chr_addr
  logic [7:0]  r_row_pend;
  logic [1:0]  r_fill;       // 0 none, 1 addr, 2 code, 3 row seen since reset
  logic        r_pix;
  logic [2:0]  r_color;

  assign w_state = decode_phase(hcnt[2:0]);
  assign w_late  = (hcnt >= H_LAST_CELL);
  assign w_fc    = w_late ? 5'd0 : hcnt[7:3] + 5'd1;
  assign w_fl    = !w_late          ? vcnt[7:0] :
                   (vcnt == V_LAST) ? 8'd0      : vcnt[7:0] + 8'd1;

  // Until one complete addr/code/row sequence has run after reset, the
  // pending registers hold nothing meaningful, so load a blank cell instead.
  assign w_primed = (r_fill == 2'd3);
  assign w_load   = (w_state == ST_LOAD);

  // Fetch FSM: one step per phase slot, holding on pix_ce=0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vram_addr <= 11'd0;
      r_chr_addr  <= 11'd0;
      r_code_pal  <= 3'd0;
      r_row_pend  <= 8'h00;
      r_fill      <= 2'd0;
    end else if (pix_ce) begin
      case (w_state)
        ST_ADDR: begin
          r_vram_addr <= {page, w_fl[7:3], w_fc};
          if (r_fill == 2'd0) r_fill <= 2'd1;
        end
        ST_CODE: begin
          r_code_pal <= vram_q[7:5];
          r_chr_addr <= {vram_q, w_fl[2:0]};
          if (r_fill == 2'd1) r_fill <= 2'd2;
        end
        ST_ROW: begin
          r_row_pend <= chr_q;
          if (r_fill == 2'd2) r_fill <= 2'd3;
        end
        default: ;
      endcase
    end
  end

  tile_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce),
    .load  (w_load),
    .din   (w_primed ? r_row_pend : 8'h00),
    .cin   (w_primed ? r_code_pal : 3'd0),
    .pix   (w_pix),
    .color (w_color)
  );

  // Output register with blanking gate; fetching itself never stops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix   <= 1'b0;
      r_color <= 3'd0;
    end else if (pix_ce) begin
      if (hblank || vblank) begin
        r_pix   <= 1'b0;
        r_color <= 3'd0;
      end else begin
        r_pix   <= w_pix;
        r_color <= w_color;
      end
    end
  end

  assign vram_addr = r_vram_addr;
  assign chr_addr  = r_chr_addr;
  assign pix_out   = r_pix;
  assign pix_color = r_color;

endmodule

// File: doc/video_tile_fetch.md
VIDEO_TILE_FETCH -- requirements
Module: video_tile_fetch

Interface
REQ-001 SHALL: parameter H_TOTAL, default 384, pixels per line including blanking; multiple of 8, at least 264.
REQ-002 SHALL: parameter V_TOTAL, default 264, lines per frame including blanking.
REQ-003 SHALL: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL: pix_ce  in  1  pixel clock enable; all state advances only on clk edges with pix_ce=1.
REQ-006 SHALL: hcnt  in  9  current pixel column, 0..H_TOTAL-1; active columns 0..255.
REQ-007 SHALL: vcnt  in  9  current line, 0..V_TOTAL-1; active lines 0..255.
REQ-008 SHALL: hblank, vblank  in  1 each  blanking flags, sampled on pix_ce.
REQ-009 SHALL: page  in  1  video RAM page select; becomes vram_addr[10].
REQ-010 SHALL: vram_addr  out  11  registered tile-map read address {page,row[4:0],col[4:0]}.
REQ-011 SHALL: vram_q  in  8  tile code; valid one clk after vram_addr changes (registered-address RAM).
REQ-012 SHALL: chr_addr  out  11  registered character ROM address {code[7:0],line[2:0]}.
REQ-013 SHALL: chr_q  in  8  glyph row, MSB = leftmost pixel; one clk latency.
REQ-014 SHALL: pix_out  out  1  registered pixel bit.
REQ-015 SHALL: pix_color  out  3  registered palette select, equal to code[7:5] of the displayed tile.

Function
REQ-016 SHALL: phase = hcnt[2:0]; the FSM state is decoded from phase on each pix_ce: IDLE (phases 0,2,4,6), ADDR (1), CODE (3), ROW (5), LOAD (7).
REQ-017 SHALL: fetch column fc = 0 when hcnt >= H_TOTAL-8, else (hcnt[7:3]+1) mod 32.
REQ-018 SHALL: fetch line fl = vcnt when hcnt < H_TOTAL-8; otherwise fl = 0 if vcnt = V_TOTAL-1, else vcnt+1.
REQ-019 SHALL: in ADDR, register vram_addr <= {page, fl[7:3], fc}.
REQ-020 SHALL: in CODE, capture code_pend <= vram_q and register chr_addr <= {vram_q, fl[2:0]}.
REQ-021 SHALL: in ROW, capture row_pend <= chr_q.
REQ-022 SHALL: in LOAD, load shifter <= row_pend and color_next <= code_pend[7:5].
REQ-023 SHALL: in every non-LOAD pix_ce cycle, shift the shifter left by one with zero fill.
REQ-024 SHALL: on every pix_ce, pix_out <= shifter[7] and pix_color <= color_next; if hblank or vblank is 1, both SHALL be forced to 0.
REQ-025 SHALL: a pixel for screen column x is registered on the pix_ce edge with hcnt = x and is valid while hcnt = x+1 (latency of one pixel).
REQ-026 SHALL: fetching continues during blanking; only outputs are gated.
REQ-027 SHALL: when pix_ce = 0, all registers hold their values.
REQ-028 SHALL: if hcnt jumps (resync), the pipeline follows the new phase with no extra state; output is invalid for at most 8 pixels.
REQ-029 SHALL: pix_ce must be no faster than one clk; with pix_ce held at 1 every clk, RAM/ROM latency is satisfied because there are 2 pix_ce steps between address and capture.

Reset
REQ-030 SHALL: reset zeroes vram_addr, chr_addr, code_pend, row_pend, shifter, color_next, pix_out and pix_color.
REQ-031 SHALL: reset has priority over pix_ce.
REQ-032 SHALL: after a reset mid-line, pix_out stays 0 until the first LOAD that follows a full ADDR/CODE/ROW sequence.

Structure
REQ-033 SHALL: shared package video_pkg holds H_TOTAL/V_TOTAL defaults, the phase constants (ADDR=1, CODE=3, ROW=5, LOAD=7) and the fetch-state enum.
REQ-034 SHALL: one sub-module, tile_shifter, contains the 8-bit load/shift register and color latch, with ports clk, reset, ce, load, din[7:0], cin[2:0], pix, color.

Verification
REQ-035 SHALL: tile map all 0x00 except addr 0x001 = 0xA5, ROM code 0xA5 line 0 = 0x81, pix_ce = 1 constantly, vcnt = 0 -> pix_out = 1 at hcnt 9 and 16, and 0 at hcnt 10..15; pix_color = 5 while hcnt is 9..16.
REQ-036 SHALL: at hcnt 376..383 with vcnt = 7 -> vram_addr = 0x020 and chr_addr = {code,3'd0}; column 0 of line 8 displays correctly.
REQ-037 SHALL: at vcnt = 263 and hcnt = 380 -> vram_addr row = 0 and fl = 0; with page = 1 -> vram_addr = 0x400.
REQ-038 SHALL: with pix_ce toggling 1/0 -> the output sequence is identical to the constant-ce case, stretched by 2x, and vram_addr changes only on ce edges.
REQ-039 SHALL: hblank = 1 over a tile whose row is 0xFF -> pix_out = 0 and pix_color = 0 throughout.
REQ-040 SHALL: reset asserted at hcnt = 100 for 3 clks -> all outputs are 0 on the next edge, and correct pixels resume from the tile loaded at hcnt = 111.
